// File: rtl/sync_bus.sv
// ----------------------------------------------------------------------------
// sync_bus
//
// Brings WIDTH independent asynchronous level signals into the clk domain.
// Each bit has its own flop chain, an optional stability filter and a rise /
// fall edge detector. Bits are never treated as a coherent word, so this block
// is meant for buttons, status lines and slow control bits. It is not meant for
// data buses.
//
// Build option:
//   SYNC_BUS_FILTER_EN  When defined, a per-bit stability filter is compiled
//                       in. A new level must sit at the end of the chain for
//                       FILTER_CNT consecutive edges before sync_out follows it.
//                       When undefined, sync_out is the chain end and
//                       FILTER_CNT is ignored. The ports are the same in both
//                       builds.
//
// Parameters:
//   WIDTH       number of independent bits
//   STAGES      synchronizer flops per bit (>= 2)
//   RESET_VAL   reset value of every flop belonging to bit i is RESET_VAL[i]
//   FILTER_CNT  cycles a new level must persist (>= 1, filter build only)
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset
//   async_in    asynchronous level inputs
//   sync_out    synchronized (and optionally filtered) levels
//   rise_pulse  one-cycle pulse per bit on a 0->1 change of sync_out
//   fall_pulse  one-cycle pulse per bit on a 1->0 change of sync_out
//   any_change  OR of every rise_pulse and fall_pulse bit
// ----------------------------------------------------------------------------
module sync_bus #(
    parameter int               WIDTH      = 8,
    parameter int               STAGES     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter int               FILTER_CNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    // Reject illegal configurations at elaboration, before any logic is built.
    if (STAGES < 2) begin : g_bad_stages
        $error("sync_bus: STAGES must be at least 2");
    end
    if (FILTER_CNT < 1) begin : g_bad_filter_cnt
        $error("sync_bus: FILTER_CNT must be at least 1");
    end

    // ------------------------------------------------------------------------
    // Synchronizer chain. Only sync_q[0] samples async_in directly, so it is
    // the only flop that can go metastable. The later stages give it time to
    // resolve before anything downstream uses the value.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_d [STAGES];
    logic [WIDTH-1:0] chain_end;

    // NOTE: every element of sync_d is written on every pass through this
    // block. Leaving any path without an assignment would infer a latch.
    always_comb begin
        sync_d[0] = async_in;
        for (int k = 1; k < STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // NOTE: the chain is an array of flops, not a RAM, so every stage is
    // reset. A stage left unreset could hold a stale level that ripples out as
    // a false edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= RESET_VAL;
            end
        end else begin
            // NOTE: use non-blocking assignments so that each stage takes the
            // value its neighbour held before the edge. Blocking assignments
            // would collapse the chain into a single flop.
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
        end
    end

    assign chain_end = sync_q[STAGES-1];

`ifdef SYNC_BUS_FILTER_EN
    // ------------------------------------------------------------------------
    // Stability filter. Each bit has its own counter of consecutive cycles in
    // which the chain end has disagreed with the accepted level. The counter is
    // cleared when the two agree, and also at the moment a new level is
    // accepted. It therefore never exceeds FILTER_CNT-1, so it cannot saturate
    // or wrap.
    // ------------------------------------------------------------------------
    localparam int               CNT_W    = $clog2(FILTER_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CNT - 1);

    logic [WIDTH-1:0] filt_q;
    logic [WIDTH-1:0] filt_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (chain_end[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                // The new level has now been seen on FILTER_CNT consecutive
                // edges, including this one, so accept it.
                filt_d[i] = chain_end[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= RESET_VAL;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sync_out = filt_q;
`else
    assign sync_out = chain_end;
`endif

    // ------------------------------------------------------------------------
    // Edge detection. prev_q holds the level of sync_out from one cycle
    // earlier. prev_q resets to the same value as sync_out, so no pulse is
    // produced when reset is asserted or released. The pulses are decoded only
    // from flops, so async_in has no combinational path to any output.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;

    always_comb begin
        prev_d = sync_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= RESET_VAL;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise_pulse = sync_out & ~prev_q;
    assign fall_pulse = ~sync_out & prev_q;
    assign any_change = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_sync_bus.sv
// ----------------------------------------------------------------------------
// tb_sync_bus
//
// Scoreboard bench for sync_bus. The stimulus process pushes each expected
// edge event into a queue: the cycle it should appear in, plus the expected
// rise, fall and sync_out values. A monitor pops one entry each time the DUT
// shows any pulse and compares the two. The bench runs two instances: u_dut
// uses the default parameters, and u_dut_rv uses RESET_VAL = 8'hA5 for the
// mid-filter reset case. The bench works in both builds; the expected latency
// follows SYNC_BUS_FILTER_EN.
// ----------------------------------------------------------------------------
module tb_sync_bus;

`ifdef SYNC_BUS_FILTER_EN
    localparam int LAT = 2 + 4;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        int         cyc;
        logic [7:0] rise;
        logic [7:0] fall;
        logic [7:0] out;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst1_n, rst2_n;
    logic [7:0] async1, async2;
    logic [7:0] sync1, rise1, fall1;
    logic [7:0] sync2, rise2, fall2;
    logic       any1, any2;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q1[$];
    exp_t q2[$];

    sync_bus #(
        .WIDTH(8), .STAGES(2), .RESET_VAL(8'h00), .FILTER_CNT(4)
    ) u_dut (
        .clk(clk), .rst_n(rst1_n), .async_in(async1), .sync_out(sync1),
        .rise_pulse(rise1), .fall_pulse(fall1), .any_change(any1)
    );

    sync_bus #(
        .WIDTH(8), .STAGES(2), .RESET_VAL(8'hA5), .FILTER_CNT(4)
    ) u_dut_rv (
        .clk(clk), .rst_n(rst2_n), .async_in(async2), .sync_out(sync2),
        .rise_pulse(rise2), .fall_pulse(fall2), .any_change(any2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push1(input int at, input logic [7:0] r, input logic [7:0] f,
                         input logic [7:0] o);
        exp_t e;
        e.cyc = at; e.rise = r; e.fall = f; e.out = o;
        q1.push_back(e);
    endtask

    task automatic push2(input int at, input logic [7:0] r, input logic [7:0] f,
                         input logic [7:0] o);
        exp_t e;
        e.cyc = at; e.rise = r; e.fall = f; e.out = o;
        q2.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitors. Outputs change only on posedge, so sampling on negedge is
    // safe. Any pulse that has no queued expectation is a failure. A pulse
    // that lasts two cycles therefore shows up as an unexpected second event.
    always @(negedge clk) begin
        exp_t e;
        if (any1 || rise1 != 8'h00 || fall1 != 8'h00) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb1_unexpected: rise %0h fall %0h at cycle %0d, expected no event",
                         rise1, fall1, cyc);
            end else begin
                e = q1.pop_front();
                check("sb1_cycle", cyc, e.cyc);
                check("sb1_rise", rise1, e.rise);
                check("sb1_fall", fall1, e.fall);
                check("sb1_sync_out", sync1, e.out);
                check("sb1_any_change", any1, 1);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (any2 || rise2 != 8'h00 || fall2 != 8'h00) begin
            if (q2.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb2_unexpected: rise %0h fall %0h at cycle %0d, expected no event",
                         rise2, fall2, cyc);
            end else begin
                e = q2.pop_front();
                check("sb2_cycle", cyc, e.cyc);
                check("sb2_rise", rise2, e.rise);
                check("sb2_fall", fall2, e.fall);
                check("sb2_sync_out", sync2, e.out);
                check("sb2_any_change", any2, 1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        // Reset with all inputs high: outputs stay at the reset value.
        rst1_n = 1'b0; async1 = 8'hFF;
        rst2_n = 1'b0; async2 = 8'hA5;
        step(3);
        check("rst_sync_out", sync1, 8'h00);
        check("rst_rise", rise1, 8'h00);
        check("rst_fall", fall1, 8'h00);
        check("rst_any", any1, 0);
        check("rst_rv_sync_out", sync2, 8'hA5);

        // Release reset. Expect exactly one rise pulse of FF after the full
        // latency. u_dut_rv already sees its reset value, so it stays quiet.
        rst1_n = 1'b1; rst2_n = 1'b1;
        push1(cyc + LAT, 8'hFF, 8'h00, 8'hFF);
        step(LAT - 1);
        check("rst_release_early", sync1, 8'h00);
        step(1);
        check("rst_release_out", sync1, 8'hFF);
        step(3);

        // Return to all zeros.
        async1 = 8'h00;
        push1(cyc + LAT, 8'h00, 8'hFF, 8'h00);
        step(LAT + 2);

        // Latency of a single bit.
        async1 = 8'h01;
        push1(cyc + LAT, 8'h01, 8'h00, 8'h01);
        step(LAT - 1);
        check("lat_early", sync1, 8'h00);
        step(1);
        check("lat_out", sync1, 8'h01);
        step(3);
        async1 = 8'h00;
        push1(cyc + LAT, 8'h00, 8'h01, 8'h00);
        step(LAT + 2);

        // 3-cycle pulse on bit 3. The filter rejects it; the plain chain
        // passes it through.
        n = cyc;
        async1 = 8'h08;
`ifndef SYNC_BUS_FILTER_EN
        push1(n + LAT, 8'h08, 8'h00, 8'h08);
`endif
        step(3);
        async1 = 8'h00;
`ifndef SYNC_BUS_FILTER_EN
        push1(n + 3 + LAT, 8'h00, 8'h08, 8'h00);
`endif
        step(LAT + 4);
        check("glitch3_out", sync1, 8'h00);

        // 4-cycle pulse on bit 3: accepted in both builds. The rise and fall
        // pulses are 4 cycles apart.
        n = cyc;
        async1 = 8'h08;
        push1(n + LAT, 8'h08, 8'h00, 8'h08);
        step(4);
        async1 = 8'h00;
        push1(n + 4 + LAT, 8'h00, 8'h08, 8'h00);
        step(LAT + 3);
        check("glitch4_out", sync1, 8'h00);

        // Several bits changing at once.
        async1 = 8'h0F;
        push1(cyc + LAT, 8'h0F, 8'h00, 8'h0F);
        step(LAT + 2);
        async1 = 8'hF0;
        push1(cyc + LAT, 8'hF0, 8'h0F, 8'hF0);
        step(LAT + 2);
        check("simul_out", sync1, 8'hF0);
        async1 = 8'h00;
        push1(cyc + LAT, 8'h00, 8'hF0, 8'h00);
        step(LAT + 2);

        // Reset u_dut_rv partway through filtering a change on bit 0.
        n = cyc;
        async2 = 8'hA4;
`ifndef SYNC_BUS_FILTER_EN
        push2(n + LAT, 8'h00, 8'h01, 8'hA4);
`endif
        step(4);
        rst2_n = 1'b0;
        #1;
        check("midrst_out", sync2, 8'hA5);
        check("midrst_rise", rise2, 8'h00);
        check("midrst_fall", fall2, 8'h00);
        check("midrst_any", any2, 0);
        step(2);
        rst2_n = 1'b1;
        push2(cyc + LAT, 8'h00, 8'h01, 8'hA4);
        step(LAT - 1);
        check("midrst_release_early", sync2, 8'hA5);
        step(1);
        check("midrst_release_out", sync2, 8'hA4);
        step(3);

        check("sb1_drain", q1.size(), 0);
        check("sb2_drain", q2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_bus.md
# sync_bus

Parametrised multi-bit level synchronizer with per-bit edge detection and an optional stability (glitch) filter. Brings WIDTH independent asynchronous level signals (buttons, status lines, slow control bits) into the `clk` domain through a configurable-depth flop chain. Generates single-cycle rise/fall pulses for downstream control logic. Not for multi-bit buses that must stay coherent as a word: each bit is synchronized independently.

## Interface
- `WIDTH`, 8: number of independent bits.
- `STAGES`, 2: synchronizer flops per bit; legal values ≥ 2.
- `RESET_VAL`, {WIDTH{1'b0}}: reset value of every flop of bit i is RESET_VAL[i].
- `FILTER_CNT`, 4: consecutive cycles a new value must persist before it is accepted. Legal values ≥ 1; used only when the filter is compiled in.
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `async_in` input WIDTH: asynchronous level inputs; no timing relation to `clk`.
- `sync_out` output WIDTH: synchronized (and, if enabled, filtered) levels.
- `rise_pulse` output WIDTH: bit i high for exactly one cycle when sync_out[i] goes 0→1.
- `fall_pulse` output WIDTH: bit i high for exactly one cycle when sync_out[i] goes 1→0.
- `any_change` output 1: OR of all rise_pulse and fall_pulse bits.

## Operation
- Per bit: shift chain sync[0..STAGES-1]; sync[0] samples async_in[i], sync[k] <= sync[k-1].
- No combinational path from async_in to any output. Only sync[0] may go metastable.
- Filter out: sync_out = sync[STAGES-1].
- Filter in: per-bit register `sync_out` and counter `cnt`, width $clog2(FILTER_CNT+1).
  - If sync[STAGES-1] == sync_out: cnt <= 0.
  - Else if cnt == FILTER_CNT-1: sync_out <= sync[STAGES-1], cnt <= 0.
  - Else: cnt <= cnt+1.
  - Counter saturation and wrap are impossible by construction.
- Edge detect: per-bit register prev <= sync_out.
  - rise_pulse = sync_out & ~prev.
  - fall_pulse = ~sync_out & prev.
  - Both are combinational from flops only.
- Bits are fully independent. Simultaneous changes on several bits produce simultaneous pulses on those bits and one-cycle any_change.
- Reset (any time, including mid-filter): all chain flops, sync_out and prev go to RESET_VAL; cnt goes to 0.
  - Outputs after reset: sync_out = RESET_VAL; rise_pulse, fall_pulse and any_change = 0.
  - No pulse is emitted on reset assertion or release.

## Timing
- E0 is the first clk edge sampling a new async_in level.
- Sampling uncertainty: ±1 cycle when setup/hold is violated at E0.
- Filter out: sync_out changes after edge E0+STAGES-1, i.e. STAGES cycles latency. Pulse is high during the following cycle.
- Filter in: sync_out changes after edge E0+STAGES+FILTER_CNT-1, i.e. STAGES+FILTER_CNT cycles latency. The new value must hold at sync[STAGES-1] for FILTER_CNT consecutive edges.
- Input pulse width:
  - Filter out: an input pulse shorter than one clk period may be lost.
  - Filter in: a pulse visible at the chain end for fewer than FILTER_CNT cycles is always rejected, with no output change and no pulse.
- Pulses are exactly one cycle wide. The minimum spacing between opposite pulses on one bit is 1 cycle without the filter and FILTER_CNT cycles with it.

## Configuration
- Macro `SYNC_BUS_FILTER_EN`.
- Defined: stability filter compiled in; FILTER_CNT is active and latency is STAGES+FILTER_CNT.
- Undefined: no counters or filter registers; FILTER_CNT is ignored and latency is STAGES.
- Ports are identical in both builds.

## Test plan
All scenarios use WIDTH=8, STAGES=2, FILTER_CNT=4 and RESET_VAL=8'h00 unless stated.
- Reset: hold rst_n=0 with async_in=8'hFF, then release. Required: sync_out=8'h00, no pulses while in reset; sync_out=8'hFF once latency elapses; exactly one rise_pulse=8'hFF cycle.
- Latency: filter out, async_in 8'h00→8'h01 set mid-cycle. Required: sync_out[0]=1 after 2 edges; rise_pulse[0] and any_change high for exactly 1 cycle.
- Latency with filter: filter in, same stimulus. Required: sync_out[0]=1 after 6 edges; single rise pulse.
- Glitch rejection: filter in, async_in[3] high for 3 cycles then low. Required: sync_out stays 8'h00 and there are no pulses. Repeat with a 4-cycle high: accepted, with one rise pulse and one fall pulse 4 cycles apart.
- Simultaneous bits: async_in 8'h0F→8'hF0 in one cycle. Required: rise_pulse=8'hF0 and fall_pulse=8'h0F in the same cycle; any_change high for 1 cycle.
- Reset mid-filter: filter in, RESET_VAL=8'hA5. Assert rst_n after cnt reaches 2 on bit 0. Required: immediate sync_out=8'hA5 with cnt cleared. After release, a stable input still needs the full 6-cycle latency.
